// File: rtl/uart_prog_loader_pkg.sv
// Purpose: shared state encodings and default timing constant for the UART program loader.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_prog_loader_pkg;

  // Bit period for a 10 MHz loader clock at 115200 baud.
  localparam int DEFAULT_CLKS_PER_BIT = 87;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    LD_WAIT,
    LD_LOAD_I,
    LD_LOAD_D,
    LD_FIN
  } ld_state_t;

endpackage

// File: rtl/uart_prog_loader_uart_rx_byte.sv
// Purpose: 8N1 UART byte receiver with a 2-FF input synchronizer.
// Latency: byte_valid one cycle after the mid-stop-bit sample.
// Backpressure: none; a byte is presented for exactly one cycle.
// Ports: i_clock/i_rst (sync, active-high), i_rx (async serial, idles high),
//        o_byte_data (last good byte), o_byte_valid (1-cycle pulse),
//        o_stop_err (1-cycle pulse on a low stop bit).
module uart_rx_byte
  import uart_prog_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       i_clock,
  input  logic       i_rst,
  input  logic       i_rx,
  output logic [7:0] o_byte_data,
  output logic       o_byte_valid,
  output logic       o_stop_err
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  rx_state_t     r_state;
  logic          r_sync1;
  logic          r_sync2;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic [7:0]    r_data;
  logic          r_valid;
  logic          r_stop_err;
  logic          w_rx;

  assign w_rx         = r_sync2;
  assign o_byte_data  = r_data;
  assign o_byte_valid = r_valid;
  assign o_stop_err   = r_stop_err;

  always_ff @(posedge i_clock) begin
    if (i_rst) begin
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_state    <= RX_IDLE;
      r_cnt      <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_stop_err <= 1'b0;
    end else begin
      r_sync1    <= i_rx;
      r_sync2    <= r_sync1;
      r_valid    <= 1'b0;
      r_stop_err <= 1'b0;
      case (r_state)
        RX_IDLE: begin
          r_cnt     <= '0;
          r_bit_idx <= '0;
          if (!w_rx) r_state <= RX_START;
        end
        RX_START: begin
          // Resample mid start bit; a high here was only a glitch.
          if (r_cnt == HALF_M1) begin
            r_cnt   <= '0;
            r_state <= w_rx ? RX_IDLE : RX_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (r_cnt == FULL_M1) begin
            r_cnt   <= '0;
            r_shift <= {w_rx, r_shift[7:1]};  // LSB arrives first
            if (r_bit_idx == 3'd7) r_state <= RX_STOP;
            else                   r_bit_idx <= r_bit_idx + 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          // Back in IDLE half a bit early, so back-to-back frames are not lost.
          if (r_cnt == FULL_M1) begin
            r_cnt   <= '0;
            r_state <= RX_IDLE;
            if (w_rx) begin
              r_valid <= 1'b1;
              r_data  <= r_shift;
            end else begin
              r_stop_err <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_prog_loader.sv
// Purpose: loads a UART byte stream as big-endian words into IMEM then DMEM while holding the CPU.
// Latency: write strobe one cycle after the byte that completes a word.
// Backpressure: none; the UART stream is never stalled, bytes outside a load are dropped.
// Ports: i_clock/i_rst (sync, active-high), i_load_en (level, loader owns memories),
//        i_uart_rx (async serial), o_imem_we/o_dmem_we (1-cycle strobes),
//        o_mem_addr/o_mem_wdata (registered word address/data), o_cpu_hold,
//        o_done (sticky, DMEM full), o_frame_err (sticky, bad stop bit seen).
module uart_prog_loader
  import uart_prog_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int IMEM_WORDS   = 16384,
  parameter int DMEM_WORDS   = 16384,
  parameter int ADDR_W       = 14
) (
  input  logic              i_clock,
  input  logic              i_rst,
  input  logic              i_load_en,
  input  logic              i_uart_rx,
  output logic              o_imem_we,
  output logic              o_dmem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic              o_cpu_hold,
  output logic              o_done,
  output logic              o_frame_err
);

  localparam logic [ADDR_W-1:0] IMEM_LAST = ADDR_W'(IMEM_WORDS - 1);
  localparam logic [ADDR_W-1:0] DMEM_LAST = ADDR_W'(DMEM_WORDS - 1);

  ld_state_t         r_state;
  logic [1:0]        r_byte_cnt;
  logic [23:0]       r_partial;
  logic              r_imem_we;
  logic              r_dmem_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_cpu_hold;
  logic              r_done;
  logic              r_frame_err;

  logic [7:0]        w_byte_data;
  logic              w_byte_valid;
  logic              w_stop_err;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .i_clock     (i_clock),
    .i_rst       (i_rst),
    .i_rx        (i_uart_rx),
    .o_byte_data (w_byte_data),
    .o_byte_valid(w_byte_valid),
    .o_stop_err  (w_stop_err)
  );

  assign o_imem_we   = r_imem_we;
  assign o_dmem_we   = r_dmem_we;
  assign o_mem_addr  = r_addr;
  assign o_mem_wdata = r_wdata;
  assign o_cpu_hold  = r_cpu_hold;
  assign o_done      = r_done;
  assign o_frame_err = r_frame_err;

  always_ff @(posedge i_clock) begin
    if (i_rst) begin
      r_state     <= LD_WAIT;
      r_byte_cnt  <= '0;
      r_partial   <= '0;
      r_imem_we   <= 1'b0;
      r_dmem_we   <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cpu_hold  <= 1'b0;
      r_done      <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_imem_we  <= 1'b0;
      r_dmem_we  <= 1'b0;
      // Lags the state by one cycle so the CPU is released only after the last strobe.
      r_cpu_hold <= (r_state == LD_LOAD_I) || (r_state == LD_LOAD_D);
      if (w_stop_err) r_frame_err <= 1'b1;

      // Address moves on once its strobe has been issued; each segment wraps to 0.
      if (r_imem_we) r_addr <= (r_addr == IMEM_LAST) ? '0 : r_addr + 1'b1;
      if (r_dmem_we) r_addr <= (r_addr == DMEM_LAST) ? '0 : r_addr + 1'b1;

      case (r_state)
        LD_WAIT: begin
          if (i_load_en) begin
            r_state     <= LD_LOAD_I;
            r_addr      <= '0;
            r_byte_cnt  <= '0;
            r_partial   <= '0;
            r_done      <= 1'b0;
            r_frame_err <= 1'b0;
          end
        end
        LD_LOAD_I, LD_LOAD_D: begin
          if (!i_load_en) begin
            r_state    <= LD_WAIT;
            r_byte_cnt <= '0;
            r_partial  <= '0;
          end else if (w_byte_valid) begin
            r_byte_cnt <= r_byte_cnt + 1'b1;
            r_partial  <= {r_partial[15:0], w_byte_data};
            if (r_byte_cnt == 2'd3) begin
              r_wdata <= {r_partial, w_byte_data};
              if (r_state == LD_LOAD_I) begin
                r_imem_we <= 1'b1;
                if (r_addr == IMEM_LAST) r_state <= LD_LOAD_D;
              end else begin
                r_dmem_we <= 1'b1;
                if (r_addr == DMEM_LAST) begin
                  r_done  <= 1'b1;
                  r_state <= LD_FIN;
                end
              end
            end
          end
        end
        LD_FIN: begin
          // Dropping load_en here lets a later rising edge start a fresh load.
          if (!i_load_en) r_state <= LD_WAIT;
        end
        default: r_state <= LD_WAIT;
      endcase
    end
  end

endmodule
